ptmch_spigen: RTL and testbench
===============================

// Module: ptmch_spigen
// PURPOSE
//  SPI-NAND command generator (SPI master) for the ptmch pattern-match path. Issues the five flash
//  commands the trigger path decodes (PRGEXCT 0x10, RDSTAT 0x0F, BLKERS 0xD8, PDREAD 0x13,
//  WRSTAT 0x1F) with a 24-bit address on SPI_CS/SPI_CLK/SPI_MOSI. Used on-board to drive the
//  trigger path in loopback and as a stand-alone flash stimulus source. Mode 0, MSB first.
// PARAMETERS
//  CLK_DIV   4   SPI_CLK half-period in CLK100M cycles (>=2); 4 -> 12.5 MHz
//  CS_GAP    8   minimum SPI_CS high cycles between frames (>=1)
// PORTS
//  CLK100M    in   1   sole clock
//  RESET      in   1   asynchronous, active-high reset
//  CMD_VALID  in   1   command request; accepted when CMD_VALID & CMD_READY
//  CMD_READY  out  1   high only in IDLE
//  CMD_SEL    in   3   0 PRGEXCT,1 RDSTAT,2 BLKERS,3 PDREAD,4 WRSTAT (TRG_PLS bit order); 5-7 illegal
//  CMD_ADDR   in   24  page cmds: 24-bit address; status cmds: [15:8] reg addr, [7:0] write data
//  BUSY       out  1   high from accept until DONE/ERR
//  DONE       out  1   1-cycle pulse at frame(s) completion
//  ERR        out  1   1-cycle pulse on illegal CMD_SEL
//  RD_DATA    out  8   last byte captured by RDSTAT; held until next RDSTAT
//  SPI_CS     out  1   chip select, active low
//  SPI_CLK    out  1   serial clock, idle low
//  SPI_MOSI   out  1   serial data out
//  SPI_MISO   in   1   serial data in, sampled on SPI_CLK rising tick
// BEHAVIOUR
//  Reset: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, CMD_READY=1 after release, BUSY/DONE/ERR=0, RD_DATA=0.
//  Frame: opcode byte + 24 address bits (page cmds, N=32) or opcode + CMD_ADDR[15:0] (status
//   cmds, N=24; RDSTAT sends 0x00 as last byte and captures MISO into RD_DATA).
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   IDLE: on accept latch CMD_SEL/CMD_ADDR, build shift reg, BUSY=1, READY=0; illegal SEL: ERR
//    pulse next cycle, no frame, stay IDLE (READY stays 1).
//   SETUP: SPI_CS=0, MOSI=bit N-1, hold CLK_DIV cycles.
//   SHIFT: every CLK_DIV cycles toggle SPI_CLK; rising: sample MISO; falling: shift MOSI to next
//    bit. Ends after N-th falling edge (SPI_CLK back to 0). 2N half-periods.
//   HOLD: CS low CLK_DIV cycles, then SPI_CS=1, MOSI=0.
//   GAP: CS_GAP cycles; on exit DONE=1 one cycle, BUSY=0, READY=1 same cycle as return to IDLE.
//  CS low window = CLK_DIV*(2N+2) cycles exactly.
//  CMD_VALID while BUSY: ignored, not queued. CMD_SEL/ADDR changes after accept: no effect.
//  Bit counter 6 bits, counts down N-1..0; no wrap. Divider counter reloads on every tick.
//  RESET mid-frame: SPI_CS rises asynchronously, no DONE; partial RD_DATA discarded (0).
// CONFIGURATION
//  PTMCH_SPIGEN_BUSYPOLL_EN defined: after PRGEXCT/BLKERS/PDREAD frame, GAP goes to an automatic
//   RDSTAT of status reg 0xC0, repeated (each with full SETUP..GAP) until captured bit0 (OIP)==0;
//   DONE only after the poll frame that sees OIP=0; RD_DATA holds last polled byte.
//  Undefined: DONE after the single command frame; no automatic polling.
// STRUCTURE
//  ptmch_pkg: opcode constants (P_OP_PRGEXCT..P_OP_WRSTAT), cmd_sel_e enum, spigen state_e enum,
//   P_STAT_ADDR_C0 = 8'hC0, P_OIP_BIT = 0.
//  Sub-module ptmch_spigen_tick: CLK_DIV down-counter, en input, 1-cycle TICK output.
// TESTING
//  1 PRGEXCT, ADDR=24'h00_12_34 -> MOSI 0x10001234 over 32 rising edges; CS low 264 cycles; DONE 1 pulse.
//  2 RDSTAT, ADDR[15:8]=0xC0, MISO model drives 0xA5 on byte 3 -> MOSI 0x0FC000, RD_DATA=0xA5, N=24.
//  3 CMD_SEL=6 -> ERR one cycle, SPI_CS stays 1, READY stays 1; then WRSTAT 0xA0/0x7C -> 0x1FA07C.
//  4 CMD_VALID held high with back-to-back BLKERS -> second accepted only after DONE; CS high >=CS_GAP.
//  5 RESET asserted at bit 17 of PDREAD -> SPI_CS=1, SPI_CLK=0 same cycle, no DONE, READY after release.
//  6 BUSYPOLL_EN: PRGEXCT, model returns 0x01,0x01,0x00 -> three 0x0FC0xx frames, DONE after third.
//  Loop-back: drive ptmch_trg from this block -> matching TRG_PLS bit per command.

Source files
------------

// File: rtl/ptmch_spigen_pkg.sv
// Shared constants, enums and frame builder for the ptmch SPI-NAND command generator.
package ptmch_spigen_pkg;

  localparam logic [7:0] P_OP_PRGEXCT   = 8'h10;
  localparam logic [7:0] P_OP_RDSTAT    = 8'h0F;
  localparam logic [7:0] P_OP_BLKERS    = 8'hD8;
  localparam logic [7:0] P_OP_PDREAD    = 8'h13;
  localparam logic [7:0] P_OP_WRSTAT    = 8'h1F;
  localparam logic [7:0] P_STAT_ADDR_C0 = 8'hC0;
  localparam int         P_OIP_BIT      = 0;

  // Encoding follows the TRG_PLS bit order of the trigger decoder.
  typedef enum logic [2:0] {
    SEL_PRGEXCT = 3'd0,
    SEL_RDSTAT  = 3'd1,
    SEL_BLKERS  = 3'd2,
    SEL_PDREAD  = 3'd3,
    SEL_WRSTAT  = 3'd4
  } cmd_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  function automatic logic is_page(input logic [2:0] sel);
    return (sel == SEL_PRGEXCT) || (sel == SEL_BLKERS) || (sel == SEL_PDREAD);
  endfunction

  function automatic logic [7:0] opcode(input logic [2:0] sel);
    case (sel)
      SEL_PRGEXCT: return P_OP_PRGEXCT;
      SEL_RDSTAT:  return P_OP_RDSTAT;
      SEL_BLKERS:  return P_OP_BLKERS;
      SEL_PDREAD:  return P_OP_PDREAD;
      default:     return P_OP_WRSTAT;
    endcase
  endfunction

  // Frame is left-aligned in 32 bits; status frames use only the top 24.
  function automatic logic [31:0] build_frame(input logic [2:0] sel, input logic [23:0] addr);
    if (is_page(sel))
      return {opcode(sel), addr};
    else if (sel == SEL_RDSTAT)
      return {opcode(sel), addr[15:8], 16'h0000};
    else
      return {opcode(sel), addr[15:0], 8'h00};
  endfunction

endpackage

// File: rtl/ptmch_spigen_tick.sv
// SPI bit-rate divider: one-cycle tick every CLK_DIV cycles while en is high.
// Counter reloads on every tick and whenever en is low, so the first tick lands CLK_DIV cycles after en rises.
module ptmch_spigen_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= RELOAD;
    else if (!en || cnt == '0)
      cnt <= RELOAD;
    else
      cnt <= cnt - 1'b1;
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/ptmch_spigen.sv
// SPI-NAND command generator (mode 0, MSB first); DONE arrives CLK_DIV*(2N+2)+CS_GAP cycles after accept.
// CMD_READY only in IDLE, requests while busy are dropped. PTMCH_SPIGEN_BUSYPOLL_EN adds RDSTAT 0xC0 polling.
module ptmch_spigen
  import ptmch_spigen_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic        CLK100M,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [2:0]  CMD_SEL,
  input  logic [23:0] CMD_ADDR,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  RD_DATA,
  output logic        SPI_CS,
  output logic        SPI_CLK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  localparam int GW = $clog2(CS_GAP + 1);

  state_e        state_q, state_d;
  logic          tick, tick_en;
  logic          ld_user, ld_poll, err_set, done_set, rise, fall, cs_rel;
  logic [31:0]   frame_d, sr_q;
  logic [2:0]    sel_d, cur_sel_q;
  logic [5:0]    bit_cnt_q;
  logic [7:0]    rx_q, rd_data_q;
  logic [GW-1:0] gap_cnt_q;
  logic          cs_q, sclk_q, mosi_q, busy_q, done_q, err_q;
`ifdef PTMCH_SPIGEN_BUSYPOLL_EN
  logic          polling_q;
`endif

  assign tick_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

  ptmch_spigen_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (CLK100M),
    .rst  (RESET),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge CLK100M or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ld_user  = 1'b0;
    ld_poll  = 1'b0;
    err_set  = 1'b0;
    done_set = 1'b0;
    rise     = 1'b0;
    fall     = 1'b0;
    cs_rel   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          if (CMD_SEL <= 3'd4) begin
            ld_user = 1'b1;
            state_d = ST_SETUP;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            rise = 1'b1;
          end else begin
            fall = 1'b1;
            if (bit_cnt_q == 6'd0) state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          cs_rel  = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
`ifdef PTMCH_SPIGEN_BUSYPOLL_EN
          // Page ops chain into status polls until the device clears OIP.
          if (is_page(cur_sel_q) || (polling_q && rd_data_q[P_OIP_BIT])) begin
            ld_poll = 1'b1;
            state_d = ST_SETUP;
          end else
`endif
          begin
            done_set = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sel_d   = ld_poll ? SEL_RDSTAT : CMD_SEL;
  assign frame_d = build_frame(sel_d, ld_poll ? {8'h00, P_STAT_ADDR_C0, 8'h00} : CMD_ADDR);

  always_ff @(posedge CLK100M or posedge RESET) begin
    if (RESET) begin
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      cur_sel_q <= '0;
      gap_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= done_set;
      err_q  <= err_set;
      if (ld_user || ld_poll) begin
        cur_sel_q <= sel_d;
        cs_q      <= 1'b0;
        mosi_q    <= frame_d[31];
        sr_q      <= {frame_d[30:0], 1'b0};
        bit_cnt_q <= is_page(sel_d) ? 6'd31 : 6'd23;
        busy_q    <= 1'b1;
      end
      if (rise) begin
        sclk_q <= 1'b1;
        rx_q   <= {rx_q[6:0], SPI_MISO};
      end
      if (fall) begin
        sclk_q <= 1'b0;
        if (bit_cnt_q != 6'd0) begin
          bit_cnt_q <= bit_cnt_q - 6'd1;
          mosi_q    <= sr_q[31];
          sr_q      <= {sr_q[30:0], 1'b0};
        end
      end
      if (cs_rel) begin
        cs_q      <= 1'b1;
        mosi_q    <= 1'b0;
        gap_cnt_q <= GW'(CS_GAP - 1);
        if (cur_sel_q == SEL_RDSTAT) rd_data_q <= rx_q;
      end
      if (state_q == ST_GAP && gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - 1'b1;
      if (done_set) busy_q <= 1'b0;
    end
  end

`ifdef PTMCH_SPIGEN_BUSYPOLL_EN
  always_ff @(posedge CLK100M or posedge RESET) begin
    if (RESET)        polling_q <= 1'b0;
    else if (ld_poll) polling_q <= 1'b1;
    else if (ld_user || done_set) polling_q <= 1'b0;
  end
`endif

  assign CMD_READY = (state_q == ST_IDLE) && !RESET;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign RD_DATA   = rd_data_q;
  assign SPI_CS    = cs_q;
  assign SPI_CLK   = sclk_q;
  assign SPI_MOSI  = mosi_q;

endmodule

// File: tb/tb_ptmch_spigen.sv
// Directed bench for ptmch_spigen: SPI slave monitor/MISO model plus hand-computed frame expectations.
module tb_ptmch_spigen;

`ifdef PTMCH_SPIGEN_BUSYPOLL_EN
  localparam int POLL = 1;
`else
  localparam int POLL = 0;
`endif

  logic        CLK100M = 1'b0;
  logic        RESET;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [2:0]  CMD_SEL;
  logic [23:0] CMD_ADDR;
  logic        BUSY, DONE, ERR;
  logic [7:0]  RD_DATA;
  logic        SPI_CS, SPI_CLK, SPI_MOSI;
  logic        spi_miso;

  int checks = 0;
  int errors = 0;

  ptmch_spigen #(.CLK_DIV(4), .CS_GAP(8)) dut (
    .CLK100M  (CLK100M),
    .RESET    (RESET),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_SEL  (CMD_SEL),
    .CMD_ADDR (CMD_ADDR),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .RD_DATA  (RD_DATA),
    .SPI_CS   (SPI_CS),
    .SPI_CLK  (SPI_CLK),
    .SPI_MOSI (SPI_MOSI),
    .SPI_MISO (spi_miso)
  );

  always #5 CLK100M = ~CLK100M;

  // Slave side: MOSI capture per frame, MISO byte on bits 16..23.
  int          frames   = 0;
  int          rise_cnt = 0;
  logic [31:0] mosi_sr  = '0;
  logic [31:0] rec_mosi [16];
  int          rec_bits [16];
  logic [7:0]  miso_tab [4];
  int          miso_base = 0;
  int          miso_idx;
  logic [7:0]  miso_byte;

  always @(negedge SPI_CS or posedge SPI_CLK) begin
    if (SPI_CLK === 1'b1) begin
      mosi_sr  = {mosi_sr[30:0], SPI_MOSI};
      rise_cnt = rise_cnt + 1;
    end else begin
      mosi_sr  = '0;
      rise_cnt = 0;
      frames   = frames + 1;
    end
  end

  always @(posedge SPI_CS) begin
    rec_mosi[frames % 16] = mosi_sr;
    rec_bits[frames % 16] = rise_cnt;
  end

  always_comb begin
    miso_idx = frames - miso_base - 1;
    if (miso_idx < 0) miso_idx = 0;
    if (miso_idx > 3) miso_idx = 3;
    miso_byte = miso_tab[miso_idx];
    spi_miso  = (rise_cnt >= 16 && rise_cnt < 24) ? miso_byte[23 - rise_cnt] : 1'b0;
  end

  // CS run lengths in core cycles, plus DONE pulse count.
  logic cs_prev   = 1'b1;
  int   run_low   = 0;
  int   run_high  = 0;
  int   last_low  = 0;
  int   last_high = 0;
  int   done_cnt  = 0;

  always @(posedge CLK100M) begin
    if (SPI_CS === 1'b0) begin
      run_low <= cs_prev ? 1 : run_low + 1;
      if (cs_prev) last_high <= run_high;
    end else begin
      run_high <= cs_prev ? run_high + 1 : 1;
      if (!cs_prev) last_low <= run_low;
    end
    cs_prev <= (SPI_CS !== 1'b0);
    if (DONE === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] sel, input logic [23:0] addr);
    CMD_SEL   = sel;
    CMD_ADDR  = addr;
    CMD_VALID = 1'b1;
    @(negedge CLK100M);
    CMD_VALID = 1'b0;
    CMD_SEL   = 3'd7;
    CMD_ADDR  = 24'hFFFFFF;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (DONE !== 1'b1 && n < 3000) begin
      @(negedge CLK100M);
      n++;
    end
    chk(tag, 32'(DONE), 32'd1);
  endtask

  task automatic wait_cs_high(input string tag);
    int n = 0;
    while (SPI_CS !== 1'b1 && n < 1000) begin
      @(negedge CLK100M);
      n++;
    end
    chk(tag, 32'(SPI_CS), 32'd1);
  endtask

  int f0, d0, n;

  initial begin
    RESET = 1'b1; CMD_VALID = 1'b0; CMD_SEL = 3'd0; CMD_ADDR = '0;
    for (int i = 0; i < 4; i++) miso_tab[i] = 8'h00;
    repeat (3) @(negedge CLK100M);
    chk("rst_cs", 32'(SPI_CS), 32'd1);
    chk("rst_sclk", 32'(SPI_CLK), 32'd0);
    chk("rst_mosi", 32'(SPI_MOSI), 32'd0);
    chk("rst_busy_done_err", {29'd0, BUSY, DONE, ERR}, 32'd0);
    chk("rst_rd_data", 32'(RD_DATA), 32'd0);
    RESET = 1'b0;
    @(negedge CLK100M);
    chk("rst_ready", 32'(CMD_READY), 32'd1);

    // 1: PRGEXCT 0x001234
    f0 = frames; d0 = done_cnt; miso_base = frames;
    issue(3'd0, 24'h001234);
    chk("t1_busy", 32'(BUSY), 32'd1);
    chk("t1_ready_low", 32'(CMD_READY), 32'd0);
    chk("t1_cs_low", 32'(SPI_CS), 32'd0);
    wait_cs_high("t1_cs_rise");
    repeat (2) @(negedge CLK100M);
    chk("t1_cs_low_len", 32'(last_low), 32'd264);
    chk("t1_mosi", rec_mosi[(f0 + 1) % 16], 32'h10001234);
    chk("t1_bits", 32'(rec_bits[(f0 + 1) % 16]), 32'd32);
    chk("t1_no_done_early", 32'(done_cnt - d0), 32'd0);
    wait_done("t1_done");
    @(negedge CLK100M);
    chk("t1_done_pulse", 32'(DONE), 32'd0);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t1_frames", 32'(frames - f0), 32'(1 + POLL));
    chk("t1_idle", {30'd0, BUSY, CMD_READY}, 32'd1);

    // 2: RDSTAT reg 0xC0, slave returns 0xA5
    f0 = frames; miso_base = frames; miso_tab[0] = 8'hA5;
    issue(3'd1, 24'h00C000);
    wait_done("t2_done");
    chk("t2_mosi", rec_mosi[(f0 + 1) % 16], 32'h000FC000);
    chk("t2_bits", 32'(rec_bits[(f0 + 1) % 16]), 32'd24);
    chk("t2_cs_low_len", 32'(last_low), 32'd200);
    chk("t2_rd_data", 32'(RD_DATA), 32'h000000A5);
    @(negedge CLK100M);

    // 3: illegal select, then WRSTAT 0xA0 <- 0x7C
    f0 = frames; miso_tab[0] = 8'h00;
    issue(3'd6, 24'h123456);
    chk("t3_err", 32'(ERR), 32'd1);
    chk("t3_err_cs", 32'(SPI_CS), 32'd1);
    chk("t3_err_ready", {30'd0, CMD_READY, BUSY}, 32'd2);
    @(negedge CLK100M);
    chk("t3_err_pulse", 32'(ERR), 32'd0);
    chk("t3_err_noframe", 32'(frames - f0), 32'd0);
    issue(3'd4, 24'h00A07C);
    wait_done("t3_done");
    chk("t3_mosi", rec_mosi[(f0 + 1) % 16], 32'h001FA07C);
    chk("t3_rd_data_kept", 32'(RD_DATA), 32'h000000A5);
    @(negedge CLK100M);

    // 4: CMD_VALID held high across two BLKERS
    f0 = frames; d0 = done_cnt; miso_base = frames;
    CMD_SEL = 3'd2; CMD_ADDR = 24'hABCDEF; CMD_VALID = 1'b1;
    @(negedge CLK100M);
    wait_done("t4_done1");
    chk("t4_frames_mid", 32'(frames - f0), 32'(1 + POLL));
    @(negedge CLK100M);
    chk("t4_busy2", 32'(BUSY), 32'd1);
    wait_done("t4_done2");
    CMD_VALID = 1'b0;
    repeat (20) @(negedge CLK100M);
    chk("t4_frames", 32'(frames - f0), 32'(2 + 2 * POLL));
    chk("t4_done_cnt", 32'(done_cnt - d0), 32'd2);
    chk("t4_mosi1", rec_mosi[(f0 + 1) % 16], 32'hD8ABCDEF);
    chk("t4_mosi2", rec_mosi[(f0 + 2 + POLL) % 16], 32'hD8ABCDEF);
    chk("t4_gap", 32'(last_high >= 8), 32'd1);

    // 5: RESET during bit 17 of PDREAD
    d0 = done_cnt;
    issue(3'd3, 24'h345678);
    n = 0;
    while (rise_cnt != 17 && n < 1000) begin
      @(negedge CLK100M);
      n++;
    end
    chk("t5_reach_bit17", 32'(rise_cnt), 32'd17);
    chk("t5_sclk_high", 32'(SPI_CLK), 32'd1);
    RESET = 1'b1;
    #1;
    chk("t5_cs_async", 32'(SPI_CS), 32'd1);
    chk("t5_sclk_async", 32'(SPI_CLK), 32'd0);
    repeat (2) @(negedge CLK100M);
    RESET = 1'b0;
    @(negedge CLK100M);
    chk("t5_ready", {30'd0, CMD_READY, BUSY}, 32'd2);
    chk("t5_rd_data", 32'(RD_DATA), 32'd0);
    repeat (300) @(negedge CLK100M);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_cs_idle", 32'(SPI_CS), 32'd1);

`ifdef PTMCH_SPIGEN_BUSYPOLL_EN
    // 6: PRGEXCT then polls returning 0x01, 0x01, 0x00
    f0 = frames; d0 = done_cnt; miso_base = frames;
    miso_tab[0] = 8'hFF; miso_tab[1] = 8'h01; miso_tab[2] = 8'h01; miso_tab[3] = 8'h00;
    issue(3'd0, 24'h000777);
    wait_done("t6_done");
    chk("t6_frames", 32'(frames - f0), 32'd4);
    chk("t6_mosi0", rec_mosi[(f0 + 1) % 16], 32'h10000777);
    for (int k = 2; k <= 4; k++) chk("t6_poll", rec_mosi[(f0 + k) % 16], 32'h000FC000);
    chk("t6_rd_data", 32'(RD_DATA), 32'd0);
    @(negedge CLK100M);
    chk("t6_done_cnt", 32'(done_cnt - d0), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
